// File: rtl/axi_stream_pkg.sv
// Purpose: shared AXI-Stream types: merge FSM states, beat-length width, saturating increment.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_stream_pkg;

    localparam int LEN_W = 16;

    typedef enum logic {
        HEAD = 1'b0,
        TAIL = 1'b1
    } merge_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == {LEN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Purpose: 2-entry skid buffer; ports: clock, rst_n, in_dat_i/in_vld_i/in_rdy_o, out_dat_o/out_vld_o/out_rdy_i.
// Latency: 1 cycle from input handshake to out_vld_o; sustains 1 beat/cycle.
// Backpressure: in_rdy_o is a register, high while at most one entry is held; out side stable until taken.
module axis_skid_buffer #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic [W-1:0] in_dat_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    output logic [W-1:0] out_dat_o,
    output logic         out_vld_o,
    input  logic         out_rdy_i
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         rdy_q;
    logic         push;
    logic         pop;

    // rdy_q only rises when at most one slot is used, so a push can never overflow
    // even if the consumer stalls in the same cycle.
    assign push      = in_vld_i & rdy_q;
    assign pop       = out_vld_o & out_rdy_i;
    assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    assign in_rdy_o  = rdy_q;
    assign out_vld_o = (cnt_q != 2'd0);
    assign out_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d <= 2'd1);
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_dat_i;
    end

endmodule

// File: rtl/axi_stream_merge_channel.sv
// Purpose: rebuilds a packet from one head packet (first_*) followed by one tail packet (end_*);
//          ports: clock, rst_n, first_* / end_* slave streams, out_* master stream, first_len, merge_done.
// Latency: 1 cycle input-to-output through a 2-entry skid buffer; backpressure: tready of the selected
//          input is registered (no path from out_tready); the unselected input is held off with tready=0.
module axi_stream_merge_channel
    import axi_stream_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int USIZE = 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] first_tdata,
    input  logic [USIZE-1:0] first_tuser,
    input  logic             first_tvalid,
    input  logic             first_tlast,
    output logic             first_tready,
    input  logic [DSIZE-1:0] end_tdata,
    input  logic [USIZE-1:0] end_tuser,
    input  logic             end_tvalid,
    input  logic             end_tlast,
    output logic             end_tready,
    output logic [DSIZE-1:0] out_tdata,
    output logic [USIZE-1:0] out_tuser,
    output logic             out_tvalid,
    output logic             out_tlast,
    input  logic             out_tready,
    output logic [LEN_W-1:0] first_len,
    output logic             merge_done
);

    localparam int BW = DSIZE + USIZE + 1;

    merge_state_e     state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [BW-1:0]    buf_in_dat;
    logic             buf_in_vld;
    logic             buf_rdy;
    logic [BW-1:0]    buf_out_dat;
    logic             buf_out_vld;
    logic             head_hs;

    axis_skid_buffer #(.W(BW)) u_skid (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_dat_i  (buf_in_dat),
        .in_vld_i  (buf_in_vld),
        .in_rdy_o  (buf_rdy),
        .out_dat_o (buf_out_dat),
        .out_vld_o (buf_out_vld),
        .out_rdy_i (out_tready)
    );

    // Input select and next state. Readies are gated by rst_n so they read 0
    // throughout reset, including the first cycle before the registers clear.
    always_comb begin
        state_d      = state_q;
        buf_in_vld   = 1'b0;
        buf_in_dat   = {first_tuser, first_tdata, 1'b0};
        first_tready = 1'b0;
        end_tready   = 1'b0;
        case (state_q)
            HEAD: begin
                first_tready = rst_n & buf_rdy;
                buf_in_vld   = first_tvalid;
                // Head beats never close the output packet.
                buf_in_dat   = {first_tuser, first_tdata, 1'b0};
                if (first_tvalid && first_tready && first_tlast) state_d = TAIL;
            end
            TAIL: begin
                end_tready = rst_n & buf_rdy;
                buf_in_vld = end_tvalid;
                buf_in_dat = {end_tuser, end_tdata, end_tlast};
                if (end_tvalid && end_tready && end_tlast) state_d = HEAD;
            end
            default: state_d = HEAD;
        endcase
    end

    assign head_hs = first_tvalid & first_tready;

    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        if (head_hs) begin
            if (first_tlast) begin
                len_d = sat_inc(cnt_q);
                cnt_d = '0;
            end else begin
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= HEAD;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign out_tvalid                        = rst_n & buf_out_vld;
    assign {out_tuser, out_tdata, out_tlast} = buf_out_dat;
    assign merge_done                        = out_tvalid & out_tready & out_tlast;
    assign first_len                         = len_q;

endmodule

// File: tb/tb_axi_stream_merge_channel.sv
module tb_axi_stream_merge_channel;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [7:0]  first_tdata, end_tdata, out_tdata;
    logic [0:0]  first_tuser, end_tuser, out_tuser;
    logic        first_tvalid, first_tlast, first_tready;
    logic        end_tvalid, end_tlast, end_tready;
    logic        out_tvalid, out_tlast, out_tready;
    logic [15:0] first_len;
    logic        merge_done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int exp_done = 0;
    bit head_done;
    bit rdy_rand = 1'b0;
    logic [9:0] exp_q[$];
    bit         prev_stall = 1'b0;
    logic [9:0] prev_out;

    axi_stream_merge_channel #(.DSIZE(8), .USIZE(1)) dut (
        .clock(clock), .rst_n(rst_n),
        .first_tdata(first_tdata), .first_tuser(first_tuser), .first_tvalid(first_tvalid),
        .first_tlast(first_tlast), .first_tready(first_tready),
        .end_tdata(end_tdata), .end_tuser(end_tuser), .end_tvalid(end_tvalid),
        .end_tlast(end_tlast), .end_tready(end_tready),
        .out_tdata(out_tdata), .out_tuser(out_tuser), .out_tvalid(out_tvalid),
        .out_tlast(out_tlast), .out_tready(out_tready),
        .first_len(first_len), .merge_done(merge_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Output monitor: order, tlast, merge_done and stall stability.
    always @(negedge clock) begin
        logic [9:0] cur;
        logic [9:0] e;
        cur = {out_tuser, out_tdata, out_tlast};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_tvalid, 1);
                chk("stall_stable", cur, prev_out);
            end
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", cur, 10'h3FF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", cur, e);
                    chk("merge_done_on_beat", merge_done, e[0]);
                end
            end else begin
                chk("merge_done_idle", merge_done, 0);
            end
            if (merge_done) done_cnt++;
            prev_stall = out_tvalid && !out_tready;
            prev_out   = cur;
        end
    end

    task automatic send_head(input int n, input logic [7:0] base, input bit with_last);
        int t;
        for (int i = 0; i < n; i++) begin
            first_tdata  = base + 8'(i);
            first_tuser  = first_tdata[0];
            first_tlast  = with_last && (i == n - 1);
            first_tvalid = 1'b1;
            t = 0;
            do begin @(negedge clock); t++; end while (!first_tready && t < 500);
            chk("head_hs_timeout", (t < 500), 1);
            @(posedge clock); #1;
        end
        first_tvalid = 1'b0;
        first_tlast  = 1'b0;
        head_done    = 1'b1;
    endtask

    task automatic send_tail(input int n, input logic [7:0] base);
        int t;
        for (int i = 0; i < n; i++) begin
            end_tdata  = base + 8'(i);
            end_tuser  = end_tdata[0];
            end_tlast  = (i == n - 1);
            end_tvalid = 1'b1;
            t = 0;
            do begin
                @(negedge clock);
                t++;
                if (!head_done) chk("end_tready_early", end_tready, 0);
            end while (!(end_tready && head_done) && t < 500);
            chk("tail_hs_timeout", (t < 500), 1);
            @(posedge clock); #1;
        end
        end_tvalid = 1'b0;
        end_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin @(negedge clock); t++; end
        chk("drain_timeout", (t < 2000), 1);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic run_pair(input int hn, input logic [7:0] hb, input int tn, input logic [7:0] tb);
        logic [7:0] d;
        for (int i = 0; i < hn; i++) begin d = hb + 8'(i); exp_q.push_back({d[0], d, 1'b0}); end
        for (int i = 0; i < tn; i++) begin d = tb + 8'(i); exp_q.push_back({d[0], d, (i == tn - 1)}); end
        exp_done++;
        head_done = 1'b0;
        fork
            send_head(hn, hb, 1'b1);
            send_tail(tn, tb);
        join
        drain();
        chk("first_len", first_len, hn);
    endtask

    initial begin
        rst_n = 1'b0;
        first_tdata = '0; first_tuser = '0; first_tvalid = 1'b0; first_tlast = 1'b0;
        end_tdata = '0; end_tuser = '0; end_tvalid = 1'b0; end_tlast = 1'b0;
        out_tready = 1'b1;
        head_done = 1'b0;
        fork
            forever begin
                @(posedge clock); #1;
                if (rdy_rand) out_tready = ($urandom_range(0, 9) < 3);
            end
        join_none

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_first_tready", first_tready, 0);
        chk("rst_end_tready", end_tready, 0);
        chk("rst_first_len", first_len, 0);
        chk("rst_merge_done", merge_done, 0);
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_first_tready", first_tready, 1);
        chk("post_rst_end_tready", end_tready, 0);

        // 3-beat head + 2-beat tail; tail valid held from the start
        run_pair(3, 8'h01, 2, 8'hA0);
        chk("done_cnt_a", done_cnt, exp_done);
        // single-beat head and tail
        run_pair(1, 8'h55, 1, 8'h66);
        chk("done_cnt_b", done_cnt, exp_done);

        // random backpressure, 20 pairs
        rdy_rand = 1'b1;
        for (int k = 0; k < 20; k++)
            run_pair(1 + (k % 4), 8'(8'h80 + k * 8), 1 + ((k * 3) % 5), 8'(8'h04 + k * 8));
        rdy_rand = 1'b0;
        @(posedge clock); #1;
        out_tready = 1'b1;
        drain();
        chk("done_cnt_rand", done_cnt, exp_done);

        // reset after two head beats held in a stalled buffer
        out_tready = 1'b0;
        head_done = 1'b0;
        send_head(2, 8'h10, 1'b0);
        @(negedge clock);
        chk("pre_rst_buffered", out_tvalid, 1);
        @(posedge clock); #1;
        rst_n = 1'b0;
        @(posedge clock); #1;
        chk("mid_rst_out_tvalid", out_tvalid, 0);
        chk("mid_rst_first_len", first_len, 0);
        chk("mid_rst_first_tready", first_tready, 0);
        rst_n = 1'b1;
        out_tready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("post_rst_no_beats", done_cnt, exp_done);
        run_pair(4, 8'h20, 2, 8'h30);
        chk("done_cnt_rst", done_cnt, exp_done);

        // split-channel loopback: original packets cut at {4,1,7} and rejoined
        for (int k = 0; k < 6; k++) begin
            int hl;
            logic [7:0] b;
            hl = (k % 3 == 0) ? 4 : ((k % 3 == 1) ? 1 : 7);
            b  = 8'(8'h40 + k * 16);
            run_pair(hl, b, 2, b + 8'(hl));
        end
        chk("done_cnt_loop", done_cnt, exp_done);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_stream_merge_channel.md
AXI_STREAM_MERGE_CHANNEL -- requirements
Module: axi_stream_merge_channel

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, giving the tdata width in bits.
REQ-002 The block SHALL have parameter USIZE, default 1, giving the tuser width in bits.
REQ-003 clock  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 first_tdata/first_tuser/first_tvalid/first_tlast  input  DSIZE/USIZE/1/1  head segment stream; first_tready  output  1.
REQ-006 end_tdata/end_tuser/end_tvalid/end_tlast  input  DSIZE/USIZE/1/1  tail segment stream; end_tready  output  1.
REQ-007 out_tdata/out_tuser/out_tvalid/out_tlast  output  DSIZE/USIZE/1/1  merged stream; out_tready  input  1.
REQ-008 first_len  output  16  beat count of the head segment of the most recently merged packet.
REQ-009 merge_done  output  1  one-cycle pulse on the handshake of each merged packet's final beat.

Function
REQ-010 The block SHALL rebuild one packet per head/tail pair: all beats of one first_* packet, followed by all beats of one end_* packet, in order; it is the inverse of axi_stream_split_channel.
REQ-011 The state machine SHALL have two states: HEAD (reset state) and TAIL.
REQ-012 In HEAD, first_* SHALL feed the output buffer; end_tready SHALL be 0.
REQ-013 In TAIL, end_* SHALL feed the output buffer; first_tready SHALL be 0.
REQ-014 HEAD->TAIL SHALL occur on the first_tvalid&first_tready&first_tlast handshake; TAIL->HEAD SHALL occur on the end_tvalid&end_tready&end_tlast handshake; there are no other transitions.
REQ-015 The out_tlast of a head beat SHALL be forced to 0; the out_tlast of a tail beat SHALL equal end_tlast.
REQ-016 tdata and tuser SHALL pass through unchanged.
REQ-017 The output SHALL be a 2-entry skid buffer: latency of 1 cycle from input handshake to out_tvalid; full throughput of 1 beat/cycle when out_tready=1.
REQ-018 The selected input's tready SHALL be a registered signal that is 1 when the buffer holds at most 1 entry; no combinational path SHALL exist from out_tready to first_tready/end_tready.
REQ-019 Once out_tvalid is asserted, out_* SHALL stay stable until out_tready=1.
REQ-020 A head-beat counter SHALL increment on each head handshake and saturate at 16'hFFFF.
REQ-021 On the head tlast handshake, first_len SHALL load counter+1 (saturated), and the counter SHALL clear.
REQ-022 merge_done SHALL be 1 for exactly the cycle in which out_tvalid&out_tready&out_tlast occurs.
REQ-023 A head packet of exactly 1 beat (tlast on its first beat) SHALL give first_len=1 and go directly to TAIL.
REQ-024 A tail packet of 1 beat SHALL give an out packet whose last beat carries out_tlast=1.
REQ-025 Valid on the unselected input SHALL be ignored and SHALL NOT be consumed.
REQ-026 When the buffer is full, a head tlast handshake SHALL still change state; the buffer accepts no beat from either input until a slot frees.

Reset
REQ-027 While rst_n=0: state=HEAD, buffer empty, out_tvalid=0, first_tready=0, end_tready=0, first_len=0, merge_done=0, counter=0.
REQ-028 Reset mid-packet SHALL discard buffered beats and restart in HEAD, with no partial packet emitted after reset.

Structure
REQ-029 The state enum (HEAD, TAIL) and the 16-bit length width constant SHALL live in the shared axi_stream package.
REQ-030 The skid buffer SHALL be one sub-module, axis_skid_buffer, parameterised by DSIZE+USIZE+1.
REQ-031 Merge control and counting SHALL be in the top module, within 120-400 RTL lines in total.

Verification
REQ-032 Head 3 beats {01,02,03}, tail 2 beats {A0,A1}, out_tready=1 -> out {01,02,03,A0,A1}, tlast only on A1, first_len=3, one merge_done.
REQ-033 Head 1 beat {55}, tail 1 beat {66} -> out {55,66}, tlast on 66, first_len=1.
REQ-034 end_tvalid held 1 from reset while the head is pending -> end_tready stays 0 until the head tlast handshake, and no tail beat precedes the head.
REQ-035 out_tready at 30% random, 20 head/tail pairs -> output equals the concatenation of each pair, out_* is stable while stalled, and there is no beat loss or duplication.
REQ-036 rst_n pulsed low after 2 head beats -> out_tvalid=0 the next cycle; the following full pair merges correctly with first_len equal to its own head length.
REQ-037 Loopback through axi_stream_split_channel with split_len cycling {4,1,7} -> the merged output equals the original stream beat-for-beat.
